sub_bytes_iter: RTL and testbench

- Iterative AES SubBytes stage. Accepts a 128-bit state over a valid/ready handshake.
- Substitutes BYTES_PER_CYCLE bytes per clock using that many parallel S_BOX instances.
- Presents the substituted 128-bit state downstream over a second valid/ready handshake.
- Sits between AddRoundKey (upstream) and ShiftRows (downstream) in the round datapath.

---
 rtl/sub_bytes_iter.sv | 186 ++++++++++++++++++
 tb/tb_sub_bytes_iter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sub_bytes_iter.sv
// sub_bytes_iter - iterative AES SubBytes stage.
//
// Accepts a 128-bit state over a valid/ready handshake. It then substitutes
// BYTES_PER_CYCLE bytes per clock in place, using that many parallel S-box
// lookups, and presents the finished state downstream over a second
// valid/ready handshake.
//
// Byte k of a state sits at data[127-8k -: 8], for k = 0..15.
//
// Optional build macro SUB_BYTES_INV_EN:
//   - Adds an 'inv' input, which selects the inverse S-box (InvSubBytes).
//   - 'inv' is captured with in_data on accept.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   upstream state valid
//   in_ready   block can accept a state (IDLE only)
//   in_data    128-bit input state
//   inv        (SUB_BYTES_INV_EN only) 1 = inverse substitution
//   out_valid  substituted state available (DONE)
//   out_ready  downstream accepts
//   out_data   128-bit substituted state, same byte order as in_data
//   busy       high while in RUN or DONE

// One S-box lookup, done as combinational table reads.
module sub_bytes_iter_sbox (
  input  logic [7:0] a,
`ifdef SUB_BYTES_INV_EN
  input  logic       inv,
`endif
  output logic [7:0] y
);

  // Entry 0 is held in the most significant byte of each table.
  localparam logic [2047:0] FWD_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

`ifdef SUB_BYTES_INV_EN
  localparam logic [2047:0] INV_TABLE = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};
`endif

  // Entry a lives at bit offset (255-a)*8, which is just {~a, 3'b000}.
  logic [10:0] pos;
  assign pos = {~a, 3'b000};

`ifdef SUB_BYTES_INV_EN
  assign y = inv ? INV_TABLE[pos +: 8] : FWD_TABLE[pos +: 8];
`else
  assign y = FWD_TABLE[pos +: 8];
`endif

endmodule

module sub_bytes_iter #(
  parameter int BYTES_PER_CYCLE = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
`ifdef SUB_BYTES_INV_EN
  input  logic         inv,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  localparam int N     = 16 / BYTES_PER_CYCLE;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_GROUP = CNT_W'(N - 1);

  // Only power-of-two group sizes that divide 16 are supported.
  if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
        BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : g_bad_bpc
    $error("sub_bytes_iter: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state;
  logic [127:0]         buffer;
  logic [CNT_W-1:0]     cnt;
  logic [7:0]           sbox_in  [BYTES_PER_CYCLE];
  logic [7:0]           sbox_out [BYTES_PER_CYCLE];
`ifdef SUB_BYTES_INV_EN
  logic                 inv_q;
`endif

  // Bit offset of byte (group*BPC + j) within the 128-bit buffer.
  function automatic logic [6:0] byte_lsb(input logic [CNT_W-1:0] group, input int j);
    int k;
    k = int'(group) * BYTES_PER_CYCLE + j;
    return 7'(120 - 8 * k);
  endfunction

  // One S-box per byte lane of the current group. The group is read from
  // the buffer and written back in place.
  for (genvar j = 0; j < BYTES_PER_CYCLE; j++) begin : g_lane
    assign sbox_in[j] = buffer[byte_lsb(cnt, j) +: 8];
    sub_bytes_iter_sbox u_sbox (
      .a   (sbox_in[j]),
`ifdef SUB_BYTES_INV_EN
      .inv (inv_q),
`endif
      .y   (sbox_out[j])
    );
  end

  // The buffer holds the finished state during DONE, so it drives out_data directly.
  assign out_data = buffer;

  // Control FSM:
  //   - Accept a state in IDLE.
  //   - Walk the byte groups in RUN.
  //   - Hold the result in DONE until downstream takes it.
  // The handshake outputs are registered, so they change together with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      buffer    <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
`ifdef SUB_BYTES_INV_EN
      inv_q     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            buffer   <= in_data;
            cnt      <= '0;
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
`ifdef SUB_BYTES_INV_EN
            inv_q    <= inv;
`endif
          end
        end
        RUN: begin
          for (int j = 0; j < BYTES_PER_CYCLE; j++) begin
            buffer[byte_lsb(cnt, j) +: 8] <= sbox_out[j];
          end
          if (cnt == LAST_GROUP) begin
            cnt       <= '0;
            state     <= DONE;
            out_valid <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sub_bytes_iter.sv
// tb_sub_bytes_iter - directed bench for sub_bytes_iter.
//
// The main DUT uses the default group size (4 bytes per cycle). Four more
// instances cover the other legal group sizes for the latency and result
// sweep. When SUB_BYTES_INV_EN is defined, the bench also checks the inverse
// substitution.
//
// Latency is counted with the accept cycle as cycle 1.
module tb_sub_bytes_iter;

  localparam logic [127:0] VEC1   = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] RES1   = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [127:0] ZEROS  = 128'h0;
  localparam logic [127:0] ONES   = {16{8'hff}};
  localparam logic [127:0] RES0   = {16{8'h63}};
  localparam logic [127:0] RESF   = {16{8'h16}};
  localparam logic [127:0] OTHER  = 128'h00112233445566778899aabbccddeeff;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         inv;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;

  logic [3:0]   sw_valid;
  logic [3:0]   sw_in_ready;
  logic [3:0]   sw_out_valid;
  logic [3:0]   sw_busy;
  logic [127:0] sw_out_data [4];

  int compared   = 0;
  int mismatched = 0;

  // Free-running 10-time-unit clock.
  always #5 clk = ~clk;

  sub_bytes_iter #(.BYTES_PER_CYCLE(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
`ifdef SUB_BYTES_INV_EN
    .inv       (inv),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  // Sweep instances for group sizes 1, 2, 8 and 16. out_ready is tied high.
  for (genvar g = 0; g < 4; g++) begin : g_sweep
    localparam int SW_BPC = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 8 : 16;
    sub_bytes_iter #(.BYTES_PER_CYCLE(SW_BPC)) u_sw (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (sw_valid[g]),
      .in_ready  (sw_in_ready[g]),
      .in_data   (VEC1),
`ifdef SUB_BYTES_INV_EN
      .inv       (1'b0),
`endif
      .out_valid (sw_out_valid[g]),
      .out_ready (1'b1),
      .out_data  (sw_out_data[g]),
      .busy      (sw_busy[g])
    );
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Raise in_valid with the given data and return just after the accept
  // edge. in_valid is left high; the caller decides when to drop it.
  task automatic applyStimulus(input logic [127:0] data, input logic inv_v);
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    in_data  = data;
    inv      = inv_v;
    while (!in_ready && guard < 60) begin
      tick();
      guard++;
    end
    if (!in_ready) begin
      compared++;
      mismatched++;
      $error("[TB] FAIL accept_timeout: in_ready observed 0 expected 1");
    end
    tick();
  endtask

  // Called just after the accept edge. Returns the cycle count at which
  // out_valid was first seen high.
  task automatic waitOutValid(input string tag, output int lat);
    lat = 1;
    while (!out_valid && lat < 60) begin
      tick();
      lat++;
    end
    if (!out_valid) begin
      compared++;
      mismatched++;
      $error("[TB] FAIL %s_timeout: out_valid observed 0 expected 1", tag);
    end
  endtask

  initial begin
    int lat;
    int seen;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    inv       = 1'b0;
    out_ready = 1'b0;
    sw_valid  = '0;

    // Reset state.
    tick();
    tick();
    rst = 1'b0;
    tick();
    checkOutput("rst_out_valid", 128'(out_valid), 128'd0);
    checkOutput("rst_busy",      128'(busy),      128'd0);
    checkOutput("rst_in_ready",  128'(in_ready),  128'd1);
    checkOutput("rst_out_data",  out_data,        ZEROS);

    // FIPS-197 round-1 vector with out_ready held high.
    out_ready = 1'b1;
    applyStimulus(VEC1, 1'b0);
    in_valid = 1'b0;
    checkOutput("v1_busy_run", 128'(busy), 128'd1);
    waitOutValid("v1", lat);
    checkOutput("v1_latency",  128'(lat),      128'd5);
    checkOutput("v1_data",     out_data,       RES1);
    checkOutput("v1_in_ready_done", 128'(in_ready), 128'd0);
    tick();
    checkOutput("v1_out_valid_after", 128'(out_valid), 128'd0);
    checkOutput("v1_in_ready_after",  128'(in_ready),  128'd1);

    // Back-to-back 00 then FF with in_valid held.
    applyStimulus(ZEROS, 1'b0);
    in_data = ONES;
    waitOutValid("b2b0", lat);
    checkOutput("b2b0_data", out_data, RES0);
    tick();
    checkOutput("b2b_in_ready_after_hs", 128'(in_ready), 128'd1);
    tick();
    checkOutput("b2b_second_accept_busy",  128'(busy),     128'd1);
    checkOutput("b2b_second_accept_ready", 128'(in_ready), 128'd0);
    in_valid = 1'b0;
    waitOutValid("b2bF", lat);
    checkOutput("b2bF_latency", 128'(lat), 128'd5);
    checkOutput("b2bF_data",    out_data,  RESF);
    tick();

    // Backpressure for 10 cycles, with a competing state offered upstream.
    out_ready = 1'b0;
    applyStimulus(VEC1, 1'b0);
    in_data = OTHER;
    waitOutValid("hold", lat);
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput("hold_data",      out_data,         RES1);
      checkOutput("hold_out_valid", 128'(out_valid),  128'd1);
      checkOutput("hold_in_ready",  128'(in_ready),   128'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    checkOutput("hold_release_valid", 128'(out_valid), 128'd0);
    checkOutput("hold_release_data",  out_data,        RES1);
    tick();
    checkOutput("hold_no_second_busy",  128'(busy),      128'd0);
    checkOutput("hold_no_second_valid", 128'(out_valid), 128'd0);

    // Reset two cycles into RUN aborts the operation.
    applyStimulus(VEC1, 1'b0);
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("abort_out_valid", 128'(out_valid), 128'd0);
    checkOutput("abort_busy",      128'(busy),      128'd0);
    checkOutput("abort_in_ready",  128'(in_ready),  128'd1);
    checkOutput("abort_out_data",  out_data,        ZEROS);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid) seen++;
    end
    checkOutput("abort_no_result", 128'(seen), 128'd0);

    // Group-size sweep: same result, latency N+1 = 17, 9, 3, 2.
    for (int i = 0; i < 4; i++) begin
      int guard;
      int exp_lat;
      exp_lat = (i == 0) ? 17 : (i == 1) ? 9 : (i == 2) ? 3 : 2;
      guard = 0;
      sw_valid[i] = 1'b1;
      while (!sw_in_ready[i] && guard < 60) begin
        tick();
        guard++;
      end
      tick();
      sw_valid[i] = 1'b0;
      lat = 1;
      while (!sw_out_valid[i] && lat < 60) begin
        tick();
        lat++;
      end
      checkOutput($sformatf("sweep%0d_latency", i), 128'(lat), 128'(exp_lat));
      checkOutput($sformatf("sweep%0d_data", i), sw_out_data[i], RES1);
      tick();
      checkOutput($sformatf("sweep%0d_released", i), 128'(sw_out_valid[i]), 128'd0);
    end

`ifdef SUB_BYTES_INV_EN
    // Inverse substitution undoes the forward result.
    out_ready = 1'b1;
    applyStimulus(RES1, 1'b1);
    in_valid = 1'b0;
    inv      = 1'b0;
    waitOutValid("inv", lat);
    checkOutput("inv_latency", 128'(lat), 128'd5);
    checkOutput("inv_data",    out_data,  VEC1);
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Last-resort guard against a hung run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
